// File: rtl/ula_seq.sv
// ula_seq: self-running LFSR stimulus initiator for a combinational 16-bit ULA,
// emitting one operand/control/result record per operation over valid/ready.
// Optional feature macro ULA_SEQ_STALLCNT_EN adds the saturating stall_cnt output.
module ula_seq #(
  parameter logic [7:0]  N_OPS    = 8'd10,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [4:0]  CTRL_MAX = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] operandoA,
  output logic [15:0] operandoB,
  output logic [4:0]  controle,
  input  logic [15:0] resultadoOp,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [15:0] rec_opA,
  output logic [15:0] rec_opB,
  output logic [4:0]  rec_ctrl,
  output logic [15:0] rec_res,
  output logic [7:0]  rec_idx
`ifdef ULA_SEQ_STALLCNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic [4:0]  r_ctrl;
  logic [7:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;
  logic [15:0] r_rec_a;
  logic [15:0] r_rec_b;
  logic [4:0]  r_rec_ctrl;
  logic [15:0] r_rec_res;
  logic [7:0]  r_rec_idx;

  logic [15:0] w_seed_1;
  logic [15:0] w_seed_2;
  logic [15:0] w_lfsr_1;
  logic [15:0] w_lfsr_2;
  logic [4:0]  w_ctrl_next;
  logic        w_last;

  assign w_seed_1    = lfsr_next(SEED_EFF);
  assign w_seed_2    = lfsr_next(w_seed_1);
  assign w_lfsr_1    = lfsr_next(r_lfsr);
  assign w_lfsr_2    = lfsr_next(w_lfsr_1);
  assign w_ctrl_next = (r_ctrl >= CTRL_MAX) ? 5'd0 : r_ctrl + 5'd1;
  assign w_last      = (r_idx == N_OPS - 8'd1);

  // NOTE: every register, outputs included, is cleared by the async reset so an
  // aborted run leaves nothing half-emitted; non-blocking assignments keep each
  // edge reading only the previous cycle's state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lfsr     <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_ctrl     <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_rec_a    <= '0;
      r_rec_b    <= '0;
      r_rec_ctrl <= '0;
      r_rec_res  <= '0;
      r_rec_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (N_OPS != 8'd0) begin
              r_op_a  <= SEED_EFF;
              r_op_b  <= w_seed_1;
              r_lfsr  <= w_seed_2;
              r_ctrl  <= '0;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_SETTLE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          // The ULA has had one full cycle to settle on the driven operands.
          r_rec_a    <= r_op_a;
          r_rec_b    <= r_op_b;
          r_rec_ctrl <= r_ctrl;
          r_rec_idx  <= r_idx;
          r_rec_res  <= resultadoOp;
          r_valid    <= 1'b1;
          r_state    <= S_EMIT;
        end
        S_EMIT: begin
          if (r_valid && rec_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_op_a  <= r_lfsr;
              r_op_b  <= w_lfsr_1;
              r_lfsr  <= w_lfsr_2;
              r_ctrl  <= w_ctrl_next;
              r_state <= S_SETTLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ULA_SEQ_STALLCNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall <= '0;
    end else if (r_state == S_EMIT && r_valid && !rec_ready && r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign operandoA = r_op_a;
  assign operandoB = r_op_b;
  assign controle  = r_ctrl;
  assign rec_valid = r_valid;
  assign rec_opA   = r_rec_a;
  assign rec_opB   = r_rec_b;
  assign rec_ctrl  = r_rec_ctrl;
  assign rec_res   = r_rec_res;
  assign rec_idx   = r_rec_idx;

endmodule
